// File: rtl/instruction_fetch_pkg.sv
// Shared opcodes, field positions and helpers for the fetch unit.
package instruction_fetch_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'h1;
  localparam logic [3:0] OP_CALL = 4'h2;
  localparam logic [3:0] OP_RET  = 4'h3;

  localparam int INSN_OP_HI = 27;
  localparam int INSN_A_HI  = 23;
  localparam int INSN_A_LO  = 16;
  localparam int RAS_DEPTH  = 8;

  typedef enum logic [1:0] {
    F_SEQ,
    F_JMP,
    F_CALL,
    F_RET
  } flow_t;

  function automatic flow_t decode_flow(
    input logic [3:0] op
  );
    flow_t f;
    f = F_SEQ;
    unique case (op)
      OP_JMP:  f = F_JMP;
      OP_CALL: f = F_CALL;
      OP_RET:  f = F_RET;
      default: f = F_SEQ;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/return_stack.sv
// Hardware return-address LIFO for CALL/RET.
// Pointer ranges 0..DEPTH; storage is unreset.
module return_stack #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH) + 1;

  logic [PW-1:0] ptr;
  logic [W-1:0]  mem [DEPTH];
  logic [PW-2:0] widx;
  logic [PW-2:0] ridx;

  assign widx  = ptr[PW-2:0];
  assign ridx  = ptr[PW-2:0] - 1'b1;
  assign full  = (ptr == PW'(DEPTH));
  assign empty = (ptr == '0);
  assign top   = mem[ridx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (push && !full) begin
      ptr <= ptr + 1'b1;
    end else if (pop && !empty) begin
      ptr <= ptr - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[widx] <= din;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, ROM addressing, output register and
// local resolution of JMP/CALL/RET with a return stack.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int INSN_W      = 28,
  parameter int STACK_DEPTH = RAS_DEPTH
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic [ADDR_W-1:0] oAddress,
  input  logic [INSN_W-1:0] iInstruction,
  input  logic              iStall,
  input  logic              iBranchTaken,
  input  logic [ADDR_W-1:0] iBranchTarget,
  output logic [INSN_W-1:0] oInstruction,
  output logic [ADDR_W-1:0] oPC,
  output logic              oValid,
  output logic              oStackOverflow,
  output logic              oStackUnderflow
);

  localparam logic [INSN_W-1:0] NOP_WORD =
    {OP_NOP, {(INSN_W-4){1'b0}}};

  logic [ADDR_W-1:0] pc_q, pc_n;
  logic [INSN_W-1:0] ins_q, ins_n;
  logic [ADDR_W-1:0] opc_q, opc_n;
  logic              val_q, val_n;
  logic              ovf_q, ovf_n;
  logic              unf_q, unf_n;

  logic              push, pop;
  logic              full, empty;
  logic [ADDR_W-1:0] top;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] tgt_a;
  flow_t             flow;

  assign pc_inc = pc_q + 1'b1;
  assign tgt_a  = ADDR_W'(iInstruction[INSN_A_HI:INSN_A_LO]);
  assign flow   = decode_flow(
    iInstruction[INSN_OP_HI -: 4]);

  return_stack #(
    .W     (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_ras (
    .clk   (Clock),
    .rst_n (Reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .top   (top),
    .full  (full),
    .empty (empty)
  );

  // Branch and stall may coincide, so this is a priority chain.
  always_comb begin
    pc_n  = pc_q;
    ins_n = ins_q;
    opc_n = opc_q;
    val_n = val_q;
    ovf_n = ovf_q;
    unf_n = unf_q;
    push  = 1'b0;
    pop   = 1'b0;
    priority case (1'b1)
      iBranchTaken: begin
        pc_n  = iBranchTarget;
        val_n = 1'b0;
        ins_n = NOP_WORD;
      end
      iStall: begin
      end
      (flow == F_JMP): begin
        pc_n  = tgt_a;
        val_n = 1'b0;
        opc_n = pc_q;
      end
      (flow == F_CALL): begin
        pc_n  = tgt_a;
        val_n = 1'b0;
        push  = !full;
        if (full) ovf_n = 1'b1;
      end
      (flow == F_RET): begin
        val_n = 1'b0;
        pop   = !empty;
        if (empty) begin
          pc_n  = pc_inc;
          unf_n = 1'b1;
        end else begin
          pc_n  = top;
        end
      end
      default: begin
        ins_n = iInstruction;
        opc_n = pc_q;
        val_n = 1'b1;
        pc_n  = pc_inc;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pc_q  <= '0;
      ins_q <= NOP_WORD;
      opc_q <= '0;
      val_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_n;
      ins_q <= ins_n;
      opc_q <= opc_n;
      val_q <= val_n;
      ovf_q <= ovf_n;
      unf_q <= unf_n;
    end
  end

  assign oAddress        = pc_q;
  assign oInstruction    = ins_q;
  assign oPC             = opc_q;
  assign oValid          = val_q;
  assign oStackOverflow  = ovf_q;
  assign oStackUnderflow = unf_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a ROM model.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic        Clock;
  logic        Reset;
  logic [15:0] oAddress;
  logic [27:0] iInstruction;
  logic        iStall;
  logic        iBranchTaken;
  logic [15:0] iBranchTarget;
  logic [27:0] oInstruction;
  logic [15:0] oPC;
  logic        oValid;
  logic        oStackOverflow;
  logic        oStackUnderflow;

  logic [27:0] rom [256];
  int n_chk;
  int n_fail;

  instruction_fetch dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .oAddress        (oAddress),
    .iInstruction    (iInstruction),
    .iStall          (iStall),
    .iBranchTaken    (iBranchTaken),
    .iBranchTarget   (iBranchTarget),
    .oInstruction    (oInstruction),
    .oPC             (oPC),
    .oValid          (oValid),
    .oStackOverflow  (oStackOverflow),
    .oStackUnderflow (oStackUnderflow)
  );

  assign iInstruction = (oAddress < 16'd256) ?
    rom[oAddress[7:0]] : 28'h0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
        tag, got, exp);
    end
  endtask

  function automatic logic [27:0] mk(
    input logic [3:0] op,
    input logic [7:0] a
  );
    return {op, a, 16'h0};
  endfunction

  task automatic step();
    @(negedge Clock);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 256; i++) rom[i] = 28'h0;
    Reset         = 1'b0;
    iStall        = 1'b0;
    iBranchTaken  = 1'b0;
    iBranchTarget = 16'h0;
    step();
    Reset = 1'b1;
  endtask

  task automatic redirect(input logic [15:0] t);
    iBranchTaken  = 1'b1;
    iBranchTarget = t;
    step();
    iBranchTaken  = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;

    // 1: reset and straight line
    do_reset();
    chk("rst_addr", 32'(oAddress), 0);
    chk("rst_valid", 32'(oValid), 0);
    chk("rst_insn", 32'(oInstruction), 0);
    chk("rst_flags",
      32'({oStackOverflow, oStackUnderflow}), 0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("seq_addr", 32'(oAddress), 32'(k));
      chk("seq_pc", 32'(oPC), 32'(k - 1));
      chk("seq_valid", 32'(oValid), 1);
    end

    // 2: jump loop 15 <-> 16
    do_reset();
    rom[16] = mk(OP_JMP, 8'd15);
    redirect(16'd15);
    chk("jr_addr", 32'(oAddress), 15);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("jl_addr16", 32'(oAddress), 16);
      chk("jl_valid1", 32'(oValid), 1);
      step();
      chk("jl_addr15", 32'(oAddress), 15);
      chk("jl_valid0", 32'(oValid), 0);
    end
    chk("jl_ptr", 32'(dut.u_ras.ptr), 0);

    // 3: call / return
    do_reset();
    rom[4] = mk(OP_CALL, 8'd7);
    rom[7] = 28'h5_AB_CD_EF;
    rom[8] = mk(OP_RET, 8'd0);
    repeat (4) step();
    chk("cr_addr4", 32'(oAddress), 4);
    step();
    chk("cr_addr7", 32'(oAddress), 7);
    chk("cr_ptr1", 32'(dut.u_ras.ptr), 1);
    chk("cr_val0", 32'(oValid), 0);
    step();
    chk("cr_addr8", 32'(oAddress), 8);
    chk("cr_insn7", 32'(oInstruction), 32'h5ABCDEF);
    chk("cr_opc7", 32'(oPC), 7);
    step();
    chk("cr_addr5", 32'(oAddress), 5);
    chk("cr_ptr0", 32'(dut.u_ras.ptr), 0);
    chk("cr_flags",
      32'({oStackOverflow, oStackUnderflow}), 0);

    // 4: overflow after nine nested calls
    do_reset();
    for (int k = 0; k < 9; k++)
      rom[k] = mk(OP_CALL, 8'(k + 1));
    repeat (8) step();
    chk("ov_ptr8a", 32'(dut.u_ras.ptr), 8);
    chk("ov_flag0", 32'(oStackOverflow), 0);
    step();
    chk("ov_flag1", 32'(oStackOverflow), 1);
    chk("ov_addr9", 32'(oAddress), 9);
    chk("ov_ptr8b", 32'(dut.u_ras.ptr), 8);

    // 5: underflow
    do_reset();
    rom[20] = mk(OP_RET, 8'd0);
    redirect(16'd20);
    step();
    chk("un_flag", 32'(oStackUnderflow), 1);
    chk("un_addr", 32'(oAddress), 21);
    step();
    chk("un_sticky", 32'(oStackUnderflow), 1);

    // 6: redirect over a CALL, with stall, then stall
    do_reset();
    rom[0]  = mk(OP_CALL, 8'd30);
    rom[10] = 28'h5_12_34_56;
    iStall = 1'b1;
    redirect(16'd10);
    iStall = 1'b0;
    chk("br_addr", 32'(oAddress), 10);
    chk("br_ptr", 32'(dut.u_ras.ptr), 0);
    chk("br_valid", 32'(oValid), 0);
    step();
    chk("br_next", 32'(oAddress), 11);
    iStall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("st_addr", 32'(oAddress), 11);
      chk("st_insn", 32'(oInstruction), 32'h5123456);
      chk("st_pc", 32'(oPC), 10);
      chk("st_valid", 32'(oValid), 1);
    end
    #1 Reset = 1'b0;
    #1;
    chk("ar_addr", 32'(oAddress), 0);
    chk("ar_insn", 32'(oInstruction), 0);
    chk("ar_pc", 32'(oPC), 0);
    chk("ar_valid", 32'(oValid), 0);
    step();
    Reset  = 1'b1;
    iStall = 1'b0;

    // PC wraps at 16'hFFFF
    redirect(16'hFFFF);
    step();
    chk("wrap_addr", 32'(oAddress), 0);
    chk("wrap_pc", 32'(oPC), 32'hFFFF);

    $display("%0d/%0d checks passed",
      n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch unit for the lab CPU. It holds the program counter and drives the address input of the combinational instruction ROM, then registers the returned 28-bit word for the decode/execute stage. It resolves unconditional control flow (`JMP`, `CALL`, `RET`) locally using a hardware return-address stack. It accepts redirects for conditional branches resolved downstream, and a stall from execute, for example while the LCD is busy.

## Interface
Parameters:
- ADDR_W, 16, program counter / ROM address width
- INSN_W, 28, instruction width: opcode[27:24], field A[23:16], field B[15:8], field C[7:0]
- STACK_DEPTH, 8, return-address stack entries (power of two)

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- oAddress  out  ADDR_W  ROM address; always equals the PC register
- iInstruction  in  INSN_W  ROM word for oAddress, available in the same cycle
- iStall  in  1  hold the PC, output register and stack
- iBranchTaken  in  1  redirect from execute (conditional branch taken)
- iBranchTarget  in  ADDR_W  redirect address
- oInstruction  out  INSN_W  registered instruction to decode
- oPC  out  ADDR_W  address of oInstruction
- oValid  out  1  oInstruction is a real instruction, not a bubble
- oStackOverflow  out  1  sticky; set by a `CALL` when the stack is full
- oStackUnderflow  out  1  sticky; set by a `RET` when the stack is empty

## Operation
- Reset values: PC=0, oInstruction={`NOP`,24'b0}, oPC=0, oValid=0, stack pointer=0, both error flags=0.
- Each edge picks exactly one case, in priority order:
  1. **Reset low:** all registers return to reset values immediately, with no clock needed.
  2. **iBranchTaken=1:**
     - PC<=iBranchTarget, oValid<=0, oInstruction<={`NOP`,24'b0}.
     - The current iInstruction is wrong-path and is discarded: no push, no pop, no jump.
     - Beats iStall.
  3. **iStall=1:** PC, oInstruction, oPC, oValid, stack and flags all hold.
  4. **iInstruction[27:24]==`JMP`:** PC<={8'b0, iInstruction[23:16]}; oValid<=0; oPC<=PC.
  5. **`CALL`:**
     - If the stack is not full: push PC+1 and set PC<={8'b0, field A}.
     - If the stack is full: do not push, set oStackOverflow, and set PC<=target anyway.
     - oValid<=0.
  6. **`RET`:**
     - If the stack is not empty: pop, and PC<=popped value.
     - If the stack is empty: PC<=PC+1 and set oStackUnderflow.
     - oValid<=0.
  7. **Otherwise:** oInstruction<=iInstruction, oPC<=PC, oValid<=1, PC<=PC+1.
- PC arithmetic is modulo 2^ADDR_W; 16'hFFFF+1 wraps to 0.
- Error flags clear only on reset.
- The stack pointer ranges 0..STACK_DEPTH. Full means pointer==STACK_DEPTH; empty means pointer==0.

## Timing
- Latency is one cycle from oAddress to oInstruction/oPC.
- Straight-line code runs at one instruction per cycle.
- `JMP`/`CALL`/`RET` each occupy one slot with oValid=0. The target is on oAddress the following cycle, so there is no further bubble.
- A taken downstream branch costs one bubble, which is the discarded wrong-path fetch.
- Asserting iBranchTaken and iStall in the same cycle is legal; the branch wins.
- An asynchronous Reset assertion mid-stall or mid-call forces reset values within the same cycle. The first fetch after release registers ROM[0] on the first rising edge with Reset high.

## Structure
- Opcode macros (`NOP`, `JMP`, `CALL`, `RET`) come from the shared Definitions.v include.
- Add to the same include: `INSN_OP_RANGE` 27:24 and `INSN_A_RANGE` 23:16 field macros, and a `RAS_DEPTH` default.
- One sub-module, `return_stack`, implements the LIFO:
  - ports: push, pop, push data, top, full, empty
  - asynchronous active-low reset of the pointer only
  - register-array storage, no reset required
- The top level holds the PC, output registers, next-PC mux and error flags.

## Test plan
1. **Reset then straight-line run.** ROM of NOPs; release Reset. Expect oAddress 0,1,2,3 on consecutive cycles, oPC trailing by one, and oValid=1 from the first edge.
2. **Jump loop.** Place `JMP` 15 at address 16 and NOP at 15. Expect oAddress 15,16,15,16 and oValid alternating 1,0; no stack change.
3. **Call/return.** Place `CALL` 7 at 4, instructions at 7, `RET` at 8. Expect oAddress 4,7,8,5, stack pointer 0→1→0, and both flags 0.
4. **Overflow.** Issue nine nested CALLs with STACK_DEPTH=8. Expect oStackOverflow=1 after the ninth, PC still at the ninth target, and pointer=8.
5. **Underflow.** Issue a `RET` on an empty stack at address 20. Expect oStackUnderflow=1 and oAddress=21 next.
6. **Redirect and stall.**
   - iBranchTaken=1, target 10, while the ROM word is `CALL` 30: expect oAddress=10 next cycle, pointer unchanged, oValid=0.
   - Then iStall for 3 cycles: oAddress, oInstruction and oPC are constant.
   - Reset pulsed low mid-stall: outputs return to reset values before the next edge.
